// File: rtl/mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : mem_loader
// Purpose  : Button-driven write front end for the display RAM (manual write,
//            address step, whole-memory fill). MEM_FILL_RAMP_EN selects the
//            ramp fill pattern instead of a constant fill.
// Revision : 1.0
// ============================================================================
module mem_loader #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 16,
    parameter int DB_CYCLES = 250000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              step_btn,
    input  logic              load_btn,
    input  logic              fill_btn,
    input  logic [DATA_W-1:0] din,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    output logic              we,
    output logic              busy,
    output logic              done
);
    localparam int               CNT_W     = $clog2(DB_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DB_CYCLES - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_FILL  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    logic [2:0] raw_btn;
    logic [2:0] press;

    assign raw_btn = {fill_btn, load_btn, step_btn};

    generate
        for (genvar b = 0; b < 3; b++) begin : g_btn
            logic             sync1_q, sync2_q, db_q, db_dly_q, press_q;
            logic [CNT_W-1:0] cnt_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sync1_q  <= 1'b0;
                    sync2_q  <= 1'b0;
                    db_q     <= 1'b0;
                    db_dly_q <= 1'b0;
                    press_q  <= 1'b0;
                    cnt_q    <= '0;
                end else begin
                    sync1_q <= raw_btn[b];
                    sync2_q <= sync1_q;
                    // Any bounce back to the debounced level restarts the count.
                    if (sync2_q == db_q) begin
                        cnt_q <= '0;
                    end else if (cnt_q == CNT_MAX) begin
                        cnt_q <= '0;
                        db_q  <= ~db_q;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                    db_dly_q <= db_q;
                    press_q  <= db_q & ~db_dly_q;
                end
            end

            assign press[b] = press_q;
        end
    endgenerate

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                we_q, we_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                fill_wr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Outputs are registered on entry to each state so we/addr/wdata line up.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        fill_wr = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (press[2]) begin
                    addr_d  = '0;
                    fill_wr = 1'b1;
                    state_d = S_FILL;
                end else if (press[1]) begin
                    wdata_d = din;
                    we_d    = 1'b1;
                    busy_d  = 1'b1;
                    state_d = S_WRITE;
                end else if (press[0]) begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            S_WRITE: begin
                addr_d  = addr_q + ADDR_W'(1);
                state_d = S_IDLE;
            end
            S_FILL: begin
                if (addr_q == ADDR_LAST) begin
                    addr_d  = '0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    addr_d  = addr_q + ADDR_W'(1);
                    fill_wr = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (fill_wr) begin
            we_d   = 1'b1;
            busy_d = 1'b1;
`ifdef MEM_FILL_RAMP_EN
            wdata_d = din + DATA_W'(addr_d);
`else
            wdata_d = din;
`endif
        end
    end

    assign addr  = addr_q;
    assign wdata = wdata_q;
    assign we    = we_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_loader
// Purpose  : Randomized scoreboard bench for mem_loader (short debounce).
// Revision : 1.0
// ============================================================================
module tb_mem_loader;
    localparam int DB   = 4;
    localparam int HOLD = DB + 8;
`ifdef MEM_FILL_RAMP_EN
    localparam bit RAMP = 1'b1;
`else
    localparam bit RAMP = 1'b0;
`endif

    typedef struct packed {
        logic [7:0]  a;
        logic [15:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        step_btn = 1'b0, load_btn = 1'b0, fill_btn = 1'b0;
    logic [15:0] din = '0;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic        we, busy, done;

    int  checks = 0;
    int  errors = 0;
    wr_t exp_q[$];
    int  exp_done = 0;
    int  done_cnt = 0;
    int  model_addr = 0;

    mem_loader #(.ADDR_W(8), .DATA_W(16), .DB_CYCLES(DB)) dut (
        .clk(clk), .rst(rst),
        .step_btn(step_btn), .load_btn(load_btn), .fill_btn(fill_btn),
        .din(din), .addr(addr), .wdata(wdata), .we(we), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] pat(input logic [15:0] d, input int a);
        return d + (RAMP ? 16'(a) : 16'd0);
    endfunction

    // Reference model: what one debounced press of each kind does to memory.
    function automatic void model_step();
        model_addr = (model_addr + 1) % 256;
    endfunction

    function automatic void model_load(input logic [15:0] d);
        exp_q.push_back('{a: 8'(model_addr), d: d});
        model_addr = (model_addr + 1) % 256;
    endfunction

    function automatic void model_fill(input logic [15:0] d);
        for (int i = 0; i < 256; i++) exp_q.push_back('{a: 8'(i), d: pat(d, i)});
        model_addr = 0;
        exp_done++;
    endfunction

    task automatic press(input logic [2:0] which, input logic [15:0] d);
        @(negedge clk);
        din = d;
        {fill_btn, load_btn, step_btn} = which;
        repeat (HOLD) @(negedge clk);
        {fill_btn, load_btn, step_btn} = 3'b000;
        repeat (HOLD) @(negedge clk);
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check("fill_done_timeout", int'(seen), 1);
        repeat (3) @(negedge clk);
    endtask

    // Monitor: every we cycle pops one expected write.
    initial begin : monitor
        int  run = 0;
        wr_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                run = 0;
                continue;
            end
            if (we) begin
                run++;
                check("busy_during_we", int'(busy), 1);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr %0h data %0h, none expected at %0t",
                             addr, wdata, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("write_addr", int'(addr), int'(e.a));
                    check("write_data", int'(wdata), int'(e.d));
                end
            end else if (run != 0) begin
                if (run > 1) check("fill_run_len", run, 256);
                run = 0;
            end
            if (done) begin
                done_cnt++;
                check("done_addr", int'(addr), 0);
                check("done_busy", int'(busy), 0);
            end
        end
    end

    initial begin : stim
        int          lat;
        bit          found;
        logic [15:0] d;
        int          op;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("quiet_after_reset", int'({addr, we, busy, done}), 0);
        end

        // Held load: single write with bounded latency, no repeat while held.
        model_load(16'hBEEF);
        din = 16'hBEEF;
        load_btn = 1'b1;
        lat = 0;
        for (int i = 1; i <= HOLD; i++) begin
            @(negedge clk);
            if (we && lat == 0) lat = i;
        end
        load_btn = 1'b0;
        repeat (HOLD) @(negedge clk);
        check("load_latency_ok", int'(lat >= DB + 3 && lat <= DB + 4), 1);
        check("addr_after_load", int'(addr), 1);

        // Short glitch must not survive the debouncer.
        load_btn = 1'b1;
        repeat (2) @(negedge clk);
        load_btn = 1'b0;
        repeat (HOLD) @(negedge clk);
        check("addr_after_glitch", int'(addr), model_addr);

        for (int n = 0; n < 30; n++) begin
            op = int'($urandom_range(0, 3));
            d  = 16'($urandom);
            case (op)
                0, 1: begin model_step(); press(3'b001, d); end
                2: begin model_load(d); press(3'b010, d); end
                default: begin
                    @(negedge clk);
                    load_btn = 1'b1;
                    repeat (2) @(negedge clk);
                    load_btn = 1'b0;
                    repeat (HOLD) @(negedge clk);
                end
            endcase
            check("addr_random", int'(addr), model_addr);
        end

        while (model_addr != 255) begin
            model_step();
            press(3'b001, 16'h0);
        end
        check("addr_at_ff", int'(addr), 255);
        model_step();
        press(3'b001, 16'h0);
        check("step_wrap", int'(addr), 0);

        model_fill(16'h1234);
        press(3'b100, 16'h1234);
        wait_done();
        check("addr_after_fill", int'(addr), 0);

        // Simultaneous fill+load, then a load press that arrives mid-fill.
        d = 16'($urandom);
        model_fill(d);
        press(3'b110, d);
        check("busy_mid_fill", int'(busy), 1);
        press(3'b010, d);
        wait_done();

        // Asynchronous abort at fill write 100.
        d = 16'($urandom);
        model_fill(d);
        press(3'b100, d);
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (we && addr == 8'd100) begin
                found = 1'b1;
                break;
            end
        end
        check("reach_write_100", int'(found), 1);
        #1 rst = 1'b1;
        #1;
        check("abort_outputs", int'({addr, wdata, we, busy, done}), 0);
        exp_q.delete();
        exp_done--;
        model_addr = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        d = 16'($urandom);
        model_load(d);
        press(3'b010, d);
        check("addr_after_abort_load", int'(addr), 1);

        repeat (10) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        check("done_count", done_cnt, exp_done);
        check("final_addr", int'(addr), model_addr);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, limit %0d ns", 2000000);
        $fatal(1);
    end

endmodule
`default_nettype wire
